// File: rtl/read_pointer_pkg.sv
// Shared definitions for the async FIFO pointer blocks (read_pointer / write_pointer).
package read_pointer_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
    localparam int unsigned PTR_WIDTH          = DEFAULT_ADDR_WIDTH + 1;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    // Works at any pointer width up to 32; callers cast the result down to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

endpackage

// File: rtl/read_pointer_gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module read_pointer_gray2bin #(
    parameter int unsigned Width = 5
) (
    input  logic [Width-1:0] i_gray,
    output logic [Width-1:0] o_bin
);

    logic [Width-1:0] w_bin;

    always_comb begin
        w_bin = '0;
        for (int i = 0; i < int'(Width); i++) begin
            w_bin[i] = ^(i_gray >> i);
        end
    end

    assign o_bin = w_bin;

endmodule

// File: rtl/read_pointer.sv
// Read-domain pointer of the async FIFO: advances on accepted reads, produces the Gray pointer
// for the write domain plus empty / almost_empty / fill level / underflow status.
module read_pointer
    import read_pointer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH          = DEFAULT_ADDR_WIDTH,
    parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH:0]   sync_wr_ptr,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  underflow
);

    localparam int unsigned PtrW = ADDR_WIDTH + 1;

    logic [PtrW-1:0] r_rd_bin;
    logic [PtrW-1:0] r_rd_gray;
    logic            r_empty;
    logic            r_almost_empty;
    logic [PtrW-1:0] r_fill;
    logic            r_underflow;

    logic            w_rd_accept;
    logic [PtrW-1:0] w_rd_bin_next;
    logic [PtrW-1:0] w_rd_gray_next;
    logic [PtrW-1:0] w_wr_bin;
    logic [PtrW-1:0] w_fill_next;
    logic            w_empty_next;
    logic            w_almost_empty_next;

    read_pointer_gray2bin #(
        .Width (PtrW)
    ) u_wr_gray2bin (
        .i_gray (sync_wr_ptr),
        .o_bin  (w_wr_bin)
    );

    // Status is computed from the post-advance pointer so the last read asserts empty at once.
    always_comb begin
        w_rd_accept         = read_en && !r_empty;
        w_rd_bin_next       = r_rd_bin + PtrW'(w_rd_accept);
        w_rd_gray_next      = PtrW'(bin2gray(32'(w_rd_bin_next)));
        w_empty_next        = (w_rd_gray_next == sync_wr_ptr);
        w_fill_next         = w_wr_bin - w_rd_bin_next;
        w_almost_empty_next = (w_fill_next <= PtrW'(ALMOST_EMPTY_THRESH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_bin       <= '0;
            r_rd_gray      <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_fill         <= '0;
            r_underflow    <= 1'b0;
        end else begin
            r_rd_bin       <= w_rd_bin_next;
            r_rd_gray      <= w_rd_gray_next;
            r_empty        <= w_empty_next;
            r_almost_empty <= w_almost_empty_next;
            r_fill         <= w_fill_next;
            r_underflow    <= read_en && r_empty;
        end
    end

    assign rd_ptr_gray  = r_rd_gray;
    assign rd_addr      = r_rd_bin[ADDR_WIDTH-1:0];
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign fill_level   = r_fill;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_read_pointer.sv
// Scoreboard bench for read_pointer: driver feeds a count-based model, monitor compares each cycle.
module tb_read_pointer;

    logic       clk;
    logic       reset;
    logic       read_en;
    logic [4:0] sync_wr_ptr;
    logic [4:0] rd_ptr_gray;
    logic [3:0] rd_addr;
    logic       empty;
    logic       almost_empty;
    logic [4:0] fill_level;
    logic       underflow;

    read_pointer #(
        .ADDR_WIDTH          (4),
        .ALMOST_EMPTY_THRESH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .read_en      (read_en),
        .sync_wr_ptr  (sync_wr_ptr),
        .rd_ptr_gray  (rd_ptr_gray),
        .rd_addr      (rd_addr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .fill_level   (fill_level),
        .underflow    (underflow)
    );

    typedef struct {
        logic [4:0] gray;
        logic [3:0] addr;
        logic       empty;
        logic       aempty;
        logic [4:0] fill;
        logic       uflow;
        int         bits;   // expected Gray bit flips vs previous cycle, -1 = don't care
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;

    // Model state: plain unbounded counts of reads taken and entries written.
    int   m_rd    = 0;
    int   m_wr    = 0;
    bit   m_empty = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] to_gray(input int v);
        int m;
        m = v % 32;
        return 5'(m ^ (m >> 1));
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus: drive, advance the model, push the expected post-edge outputs.
    task automatic step(input bit rst, input bit ren, input int wc);
        exp_t e;
        bit   acc;
        @(negedge clk);
        reset       = rst;
        read_en     = ren;
        sync_wr_ptr = to_gray(wc);
        m_wr        = wc;
        if (rst) begin
            m_rd    = 0;
            m_empty = 1;
            e = '{gray: 5'd0, addr: 4'd0, empty: 1'b1, aempty: 1'b1, fill: 5'd0, uflow: 1'b0,
                  bits: -1};
        end else begin
            acc = ren && !m_empty;
            e.uflow = ren && m_empty;
            if (acc) m_rd++;
            m_empty  = (m_wr - m_rd) == 0;
            e.gray   = to_gray(m_rd);
            e.addr   = 4'(m_rd % 16);
            e.empty  = m_empty;
            e.aempty = (m_wr - m_rd) <= 2;
            e.fill   = 5'(m_wr - m_rd);
            e.bits   = acc ? 1 : 0;
        end
        q.push_back(e);
    endtask

    // Monitor: outputs are registered, so every cycle presents one result to check.
    initial begin
        exp_t       e;
        logic [4:0] prev_gray;
        prev_gray = '0;
        while (!done) begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("rd_ptr_gray", int'(rd_ptr_gray), int'(e.gray));
                check("rd_addr", int'(rd_addr), int'(e.addr));
                check("empty", int'(empty), int'(e.empty));
                check("almost_empty", int'(almost_empty), int'(e.aempty));
                check("fill_level", int'(fill_level), int'(e.fill));
                check("underflow", int'(underflow), int'(e.uflow));
                if (e.bits >= 0)
                    check("gray_step", $countones(rd_ptr_gray ^ prev_gray), e.bits);
            end
            prev_gray = rd_ptr_gray;
        end
    end

    initial begin
        int wc;
        reset       = 1'b1;
        read_en     = 1'b0;
        sync_wr_ptr = 5'd0;

        // Reset, then underflow on an empty FIFO
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);

        // Drain 5 entries
        step(0, 0, 5);
        for (int i = 0; i < 5; i++) step(0, 1, 5);
        step(0, 1, 5);

        // Full depth from rd_bin = 0
        step(1, 0, 0);
        step(0, 0, 16);
        step(0, 0, 16);

        // Wrap: 32 reads with the writer kept ahead
        wc = 16;
        for (int i = 0; i < 32; i++) begin
            if (wc < m_rd + 16) wc++;
            step(0, 1, wc);
        end

        // Reset mid-operation with read_en held
        step(1, 0, 0);
        step(0, 0, 6);
        for (int i = 0; i < 3; i++) step(0, 1, 6);
        step(1, 1, 6);
        step(0, 0, 0);

        // Random traffic
        wc = 0;
        for (int i = 0; i < 400; i++) begin
            bit rst;
            rst = ($urandom_range(0, 49) == 0);
            if (rst) wc = 0;
            else if (wc < m_rd + 16 && $urandom_range(0, 99) < 45) wc++;
            step(rst, ($urandom_range(0, 99) < 55), wc);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", q.size(), 0);
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
